alu_ctrl_mdu: RTL and testbench

ALU_CTRL_MDU -- requirements
Module: alu_ctrl_mdu

---
 rtl/alu_ctrl_mdu.sv | 112 +++++++++++
 tb/tb_alu_ctrl_mdu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: ALU control decode plus an iterative multiply/divide unit with HI/LO.
// Multiply is shift-add, divide is restoring; both take WIDTH cycles after the start cycle.
module alu_ctrl_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [3:0]       ALUCtrl_o,
    output logic             hilo_sel_o,
    output logic [WIDTH-1:0] result_o,
    output logic             stall_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, a, b, acc, abs1, abs2, m_lo, d_rem, d_q;
    logic [WIDTH:0] m_sum, d_sh, d_sub;
    logic [2*WIDTH-1:0] prod;
    logic [3:0] f_ctrl;
    logic neg_q, neg_r, mdu_op, is_mf, start, sgn, last, d_ge;

    assign mdu_op = ALUOp_i[2] && funct_i[5:2] == 4'b0110;
    assign is_mf = ALUOp_i[2] && (funct_i == 6'b010000 || funct_i == 6'b010010);
    assign start = !rst_i && state == IDLE && valid_i && mdu_op;
    assign sgn = !funct_i[0];
    assign abs1 = (sgn && src1_i[WIDTH-1]) ? -src1_i : src1_i;
    assign abs2 = (sgn && src2_i[WIDTH-1]) ? -src2_i : src2_i;
    assign last = cnt == CNT_W'(1);
    // acc holds the running high half of the product; b shifts the multiplier out and product bits in
    assign m_sum = {1'b0, acc} + (b[0] ? {1'b0, a} : '0);
    assign m_lo = {m_sum[0], b[WIDTH-1:1]};
    assign prod = {m_sum[WIDTH:1], m_lo};
    // acc is the partial remainder; a borrow out of the subtract means the trial failed
    assign d_sh = {acc, b[WIDTH-1]};
    assign d_sub = d_sh - {1'b0, a};
    assign d_ge = !d_sub[WIDTH];
    assign d_rem = d_ge ? d_sub[WIDTH-1:0] : d_sh[WIDTH-1:0];
    assign d_q = {b[WIDTH-2:0], d_ge};
    assign busy_o = state == MUL || state == DIV;
    assign stall_o = start || busy_o;
    assign hilo_sel_o = valid_i && is_mf;
    assign result_o = hilo_sel_o ? (funct_i[1] ? lo : hi) : '0;

    always_comb begin
        f_ctrl = 4'b0000;
        case (funct_i)
            6'b100000: f_ctrl = 4'b0010;
            6'b100010: f_ctrl = 4'b0110;
            6'b100100: f_ctrl = 4'b0000;
            6'b100101: f_ctrl = 4'b0001;
            6'b101010: f_ctrl = 4'b0111;
            6'b100111: f_ctrl = 4'b1100;
            6'b010000, 6'b010010: f_ctrl = 4'b1111;
            6'b011000, 6'b011001, 6'b011010, 6'b011011: f_ctrl = 4'b0010;
            default: f_ctrl = 4'b0000;
        endcase
        ALUCtrl_o = ALUOp_i[2] ? f_ctrl : ALUOp_i[1:0] == 2'b01 ? 4'b0111 :
                    ALUOp_i[1:0] == 2'b11 ? 4'b0110 : 4'b0010;
    end

    always_comb begin
        state_n = state;
        if (state == IDLE) state_n = start ? (funct_i[1] ? DIV : MUL) : IDLE;
        else if (state == DONE) state_n = IDLE;
        else if (last) state_n = DONE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt <= '0;
            hi <= '0;
            lo <= '0;
            a <= '0;
            b <= '0;
            acc <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                a <= funct_i[1] ? abs2 : abs1;
                b <= funct_i[1] ? abs1 : abs2;
                acc <= '0;
                cnt <= CNT_W'(WIDTH);
                // a zero divisor keeps the all-ones quotient unsigned
                neg_q <= sgn && (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]) && (!funct_i[1] || |src2_i);
                neg_r <= sgn && src1_i[WIDTH-1];
            end else if (state == MUL) begin
                acc <= m_sum[WIDTH:1];
                b <= m_lo;
                cnt <= cnt - CNT_W'(1);
                if (last) {hi, lo} <= neg_q ? -prod : prod;
            end else if (state == DIV) begin
                acc <= d_rem;
                b <= d_q;
                cnt <= cnt - CNT_W'(1);
                if (last) begin
                    lo <= neg_q ? -d_q : d_q;
                    hi <= neg_r ? -d_rem : d_rem;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: random and directed stimulus checked every cycle against a behavioural model.
module tb_alu_ctrl_mdu;
    logic clk_i = 1'b0, rst_i, valid_i;
    logic [2:0] ALUOp_i;
    logic [5:0] funct_i;
    logic [31:0] src1_i, src2_i, result_o;
    logic [3:0] ALUCtrl_o;
    logic hilo_sel_o, stall_o, busy_o;

    alu_ctrl_mdu #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ALUOp_i(ALUOp_i),
        .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i), .ALUCtrl_o(ALUCtrl_o),
        .hilo_sel_o(hilo_sel_o), .result_o(result_o), .stall_o(stall_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk, n_fail;
    bit [31:0] m_hi, m_lo;
    bit [63:0] m_p;
    int m_left;
    bit m_done;

    typedef struct packed { logic [2:0] op; logic [5:0] f; logic [3:0] ctrl; } dec_t;
    typedef struct packed { logic [5:0] f; logic [31:0] a, b, hi, lo; } dir_t;

    dec_t dec_tab[18] = '{
        '{3'd0, 6'h00, 4'h2}, '{3'd1, 6'h20, 4'h7}, '{3'd2, 6'h22, 4'h2}, '{3'd3, 6'h24, 4'h6},
        '{3'd4, 6'h20, 4'h2}, '{3'd4, 6'h22, 4'h6}, '{3'd4, 6'h24, 4'h0}, '{3'd4, 6'h25, 4'h1},
        '{3'd4, 6'h2a, 4'h7}, '{3'd4, 6'h27, 4'hc}, '{3'd5, 6'h10, 4'hf}, '{3'd6, 6'h12, 4'hf},
        '{3'd7, 6'h18, 4'h2}, '{3'd4, 6'h19, 4'h2}, '{3'd4, 6'h1a, 4'h2}, '{3'd4, 6'h1b, 4'h2},
        '{3'd4, 6'h3f, 4'h0}, '{3'd4, 6'h00, 4'h0}
    };
    dir_t dir_tab[5] = '{
        '{6'h18, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1},
        '{6'h19, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE},
        '{6'h1a, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
        '{6'h1b, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF},
        '{6'h1a, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000}
    };

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_ctrl(input logic [2:0] op, input logic [5:0] f);
        logic [3:0] class_tab[4] = '{4'h2, 4'h7, 4'h2, 4'h6};
        if (!op[2]) return class_tab[op[1:0]];
        case (f)
            6'h20: return 4'h2;
            6'h22: return 4'h6;
            6'h25: return 4'h1;
            6'h2a: return 4'h7;
            6'h27: return 4'hc;
            6'h10, 6'h12: return 4'hf;
            6'h18, 6'h19, 6'h1a, 6'h1b: return 4'h2;
            default: return 4'h0;
        endcase
    endfunction

    // returns {HI, LO}
    function automatic logic [63:0] mdu_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        int q, r;
        case (f[1:0])
            2'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            2'd1: return {32'h0, a} * {32'h0, b};
            2'd2: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, a};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: return b == 0 ? {a, 32'hFFFFFFFF} : {a % b, a / b};
        endcase
    endfunction

    function automatic bit is_mdu();
        return valid_i && ALUOp_i[2] && funct_i >= 6'h18 && funct_i <= 6'h1b;
    endfunction

    // model: a started mult/div is busy for 32 cycles, then retires for one cycle with new HI/LO
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_left <= 0;
            m_done <= 0;
            m_hi <= 0;
            m_lo <= 0;
        end else if (m_left == 0 && !m_done && is_mdu()) begin
            m_left <= 32;
            m_p <= mdu_ref(funct_i, src1_i, src2_i);
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= m_p[63:32];
                m_lo <= m_p[31:0];
                m_done <= 1;
            end
        end else m_done <= 0;
    end

    always @(negedge clk_i) begin
        bit st, sel;
        logic [31:0] er;
        st = !rst_i && m_left == 0 && !m_done && is_mdu();
        sel = valid_i && ALUOp_i[2] && (funct_i == 6'h10 || funct_i == 6'h12);
        er = sel ? (funct_i == 6'h10 ? m_hi : m_lo) : 32'h0;
        chk("aluctrl", ALUCtrl_o, ref_ctrl(ALUOp_i, funct_i));
        chk("stall", stall_o, st || m_left > 0);
        chk("busy", busy_o, m_left > 0);
        chk("hilo_sel", hilo_sel_o, sel);
        chk("result", result_o, er);
    end

    task automatic issue(input logic [2:0] op, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic v, output int stalls, output logic [31:0] res);
        valid_i = v;
        ALUOp_i = op;
        funct_i = f;
        src1_i = a;
        src2_i = b;
        stalls = 0;
        @(negedge clk_i);
        while (stall_o && stalls < 100) begin
            stalls++;
            @(negedge clk_i);
        end
        chk("stall_end", stall_o, 0);
        res = result_o;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        int ns, ns2;
        logic [31:0] r, x, y;
        logic [5:0] f;
        rst_i = 1;
        valid_i = 1;
        ALUOp_i = 3'd4;
        funct_i = 6'h18;
        src1_i = 3;
        src2_i = 5;
        repeat (2) @(negedge clk_i);
        chk("rst_stall", stall_o, 0);
        chk("rst_busy", busy_o, 0);
        @(posedge clk_i);
        #1 valid_i = 0;
        @(negedge clk_i);
        chk("rst_sel", hilo_sel_o, 0);
        chk("rst_result", result_o, 0);
        @(posedge clk_i);
        #1 rst_i = 0;
        foreach (dec_tab[i]) begin
            ALUOp_i = dec_tab[i].op;
            funct_i = dec_tab[i].f;
            valid_i = !(dec_tab[i].op[2] && dec_tab[i].f inside {[6'h18:6'h1b]});
            #1;
            chk("dec_ctrl", ALUCtrl_o, dec_tab[i].ctrl);
            chk("dec_stall", stall_o, 0);
            @(posedge clk_i);
            #1;
        end
        foreach (dir_tab[i]) begin
            issue(3'd4, dir_tab[i].f, dir_tab[i].a, dir_tab[i].b, 1, ns, r);
            chk("mdu_stalls", ns, 33);
            chk("model_hi", m_hi, dir_tab[i].hi);
            chk("model_lo", m_lo, dir_tab[i].lo);
            issue(3'd4, 6'h12, $urandom, $urandom, 1, ns, r);
            chk("mflo", r, dir_tab[i].lo);
            issue(3'd4, 6'h10, $urandom, $urandom, 1, ns, r);
            chk("mfhi", r, dir_tab[i].hi);
        end
        valid_i = 1;
        ALUOp_i = 3'd4;
        funct_i = 6'h18;
        src1_i = 32'hFFFFFFFD;
        src2_i = 32'h5;
        repeat (10) @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1;
        valid_i = 0;
        #1;
        chk("midrst_stall", stall_o, 0);
        chk("midrst_busy", busy_o, 0);
        valid_i = 1;
        funct_i = 6'h10;
        #1 chk("midrst_mfhi", result_o, 0);
        @(posedge clk_i);
        #1 rst_i = 0;
        issue(3'd4, 6'h12, 0, 0, 1, ns, r);
        chk("postrst_mflo", r, 0);
        issue(3'd4, 6'h10, 0, 0, 1, ns, r);
        chk("postrst_mfhi", r, 0);
        issue(3'd4, 6'h18, 32'hFFFFFFFD, 32'h5, 1, ns, r);
        chk("postrst_stalls", ns, 33);
        issue(3'd4, 6'h12, 0, 0, 1, ns, r);
        chk("postrst_mult_lo", r, 32'hFFFFFFF1);
        issue(3'd4, 6'h18, 32'h7, 32'hFFFFFFFD, 1, ns, r);
        issue(3'd4, 6'h1a, 32'd100, 32'd7, 1, ns2, r);
        chk("b2b_mult_stalls", ns, 33);
        chk("b2b_div_stalls", ns2, 33);
        issue(3'd4, 6'h12, 0, 0, 1, ns, r);
        chk("b2b_lo", r, 32'h0000000E);
        issue(3'd4, 6'h10, 0, 0, 1, ns, r);
        chk("b2b_hi", r, 32'h00000002);
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    f = 6'h18 + 6'($urandom_range(0, 3));
                    case ($urandom_range(0, 5))
                        0: y = 0;
                        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                        2: y = y >> $urandom_range(16, 31);
                        default: ;
                    endcase
                    issue(3'd4 | 3'($urandom_range(0, 3)), f, x, y, $urandom_range(0, 7) != 0, ns, r);
                end
                4, 5: issue(3'd4 | 3'($urandom_range(0, 3)), $urandom_range(0, 1) ? 6'h10 : 6'h12, x, y, 1, ns, r);
                default: issue(3'($urandom), 6'($urandom), x, y, 1'($urandom), ns, r);
            endcase
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
